// File: rtl/cpu_ctrl_fsm.sv
// Multicycle fetch/decode/execute/memory/writeback controller for the 16-bit CR16-style datapath.
// All enables are decoded combinationally from the current state and the IR contents.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR on mem_ready
// DECODE | register file read settles, pick instruction class
// EXEC   | ALU op, writeback, PSR capture, PC+1
// MEM    | LOAD/STOR data access at Rsrc, wait on mem_ready
// BRANCH | Bcond: PC+disp8 or PC+1
// JUMP   | Jcond: PC=Rsrc or PC+1
// JAL    | Rdest=PC+1, PC=Rsrc
module cpu_ctrl_fsm #(
    parameter int         WIDTH       = 16,
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic [4:0]       flags,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [7:0]       alu_op,
    output logic             alu_imm_sel,
    output logic             imm_zext,
    output logic             psr_we,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        BRANCH = 3'd4,
        JUMP   = 3'd5,
        JAL    = 3'd6
    } state_t;

    state_t cur_state, nxt_state;

    logic [3:0] opc, cond, ext;
    logic       unused_imm;
    logic       flag_n, flag_z, flag_l, flag_f, flag_c;
    logic       is_load, is_stor, is_jal, is_jump, is_bcond;
    logic       alu_valid, alu_imm, alu_zext, no_wb, cond_true;

    assign opc        = instr[15:12];
    assign cond       = instr[11:8];
    assign ext        = instr[7:4];
    assign unused_imm = ^instr[3:0];
    assign {flag_n, flag_z, flag_l, flag_f, flag_c} = flags;

    always_comb begin
        is_load  = (opc == 4'b0100) && (ext == 4'b0000);
        is_stor  = (opc == 4'b0100) && (ext == 4'b0100);
        is_jal   = (opc == 4'b0100) && (ext == 4'b1000);
        is_jump  = (opc == 4'b0100) && (ext == 4'b1100);
        is_bcond = (opc == 4'b1100);

        case (opc)
            4'b0000: alu_valid = ext inside {4'b0001, 4'b0010, 4'b0011, 4'b0101,
                                             4'b0110, 4'b1001, 4'b1011, 4'b1101};
            4'b1000: alu_valid = ext inside {4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                             4'b0100, 4'b0110};
            4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
            4'b1001, 4'b1011, 4'b1101, 4'b1111: alu_valid = 1'b1;
            default: alu_valid = 1'b0;
        endcase

        alu_imm  = (opc inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                4'b1001, 4'b1011, 4'b1101, 4'b1111})
                   || ((opc == 4'b1000) && !ext[2]);
        alu_zext = opc inside {4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1111};
        // compares only update the PSR
        no_wb    = ((opc == 4'b0000) && (ext == 4'b1011)) || (opc == 4'b1011);
    end

    always_comb begin
        case (cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = !flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = !flag_c;
            4'b0100: cond_true = flag_l;
            4'b0101: cond_true = !flag_l;
            4'b0110: cond_true = flag_n;
            4'b0111: cond_true = !flag_n;
            4'b1000: cond_true = flag_f;
            4'b1001: cond_true = !flag_f;
            4'b1010: cond_true = !flag_l && !flag_z;
            4'b1011: cond_true = flag_l || flag_z;
            4'b1100: cond_true = !flag_n && !flag_z;
            4'b1101: cond_true = flag_n || flag_z;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= state_t'(RESET_STATE);
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        addr_sel    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 2'b00;
        alu_op      = 8'h00;
        alu_imm_sel = 1'b0;
        imm_zext    = 1'b0;
        psr_we      = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    nxt_state = DECODE;
                end
            end
            DECODE: begin
                if (is_load || is_stor) nxt_state = MEM;
                else if (is_jal)        nxt_state = JAL;
                else if (is_jump)       nxt_state = JUMP;
                else if (is_bcond)      nxt_state = BRANCH;
                else                    nxt_state = EXEC;
            end
            EXEC: begin
                alu_op = {opc, ext};
                pc_we  = 1'b1;
                if (alu_valid) begin
                    psr_we      = 1'b1;
                    reg_we      = !no_wb;
                    alu_imm_sel = alu_imm;
                    imm_zext    = alu_zext;
                end
                nxt_state = FETCH;
            end
            MEM: begin
                addr_sel = 1'b1;
                mem_req  = 1'b1;
                mem_we   = is_stor;
                if (mem_ready) begin
                    pc_we     = 1'b1;
                    reg_we    = is_load;
                    wb_sel    = is_load ? 2'b01 : 2'b00;
                    nxt_state = FETCH;
                end
            end
            BRANCH: begin
                pc_we     = 1'b1;
                pc_sel    = cond_true ? 2'b01 : 2'b00;
                nxt_state = FETCH;
            end
            JUMP: begin
                pc_we     = 1'b1;
                pc_sel    = cond_true ? 2'b10 : 2'b00;
                nxt_state = FETCH;
            end
            JAL: begin
                reg_we    = 1'b1;
                wb_sel    = 2'b10;
                pc_we     = 1'b1;
                pc_sel    = 2'b10;
                nxt_state = FETCH;
            end
            default: nxt_state = FETCH;
        endcase

        // reset quiets the datapath even though FETCH would otherwise request memory
        if (!rst_n) begin
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = 2'b00;
            addr_sel    = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            reg_we      = 1'b0;
            wb_sel      = 2'b00;
            alu_op      = 8'h00;
            alu_imm_sel = 1'b0;
            imm_zext    = 1'b0;
            psr_we      = 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: fixed vector table, hand sequences for waits/reset/flag timing,
// and random instructions checked against a per-instruction cycle-trace model.
module tb_cpu_ctrl_fsm;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic       mem_req;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic [7:0] alu_op;
        logic       alu_imm_sel;
        logic       imm_zext;
        logic       psr_we;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        string       name;
        logic [15:0] ins;
        logic [4:0]  fl;
        outs_t       exp;
    } vec_t;

    typedef struct {
        logic  rdy;
        outs_t exp;
        string name;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        mem_ready;
    logic        ir_we, pc_we, addr_sel, mem_req, mem_we, reg_we;
    logic        alu_imm_sel, imm_zext, psr_we;
    logic [1:0]  pc_sel, wb_sel;
    logic [7:0]  alu_op;
    logic [2:0]  state;
    outs_t       act;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t  vecs[$];
    step_t trace[$];

    cpu_ctrl_fsm #(.WIDTH(16), .RESET_STATE(3'd0)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .flags(flags), .mem_ready(mem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .addr_sel(addr_sel),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .alu_imm_sel(alu_imm_sel), .imm_zext(imm_zext),
        .psr_we(psr_we), .state(state)
    );

    assign act = {ir_we, pc_we, pc_sel, addr_sel, mem_req, mem_we, reg_we, wb_sel,
                  alu_op, alu_imm_sel, imm_zext, psr_we, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic outs_t mk(input logic [2:0] st, input logic ir, input logic pcw,
                                 input logic [1:0] pcs, input logic as, input logic rq,
                                 input logic mw, input logic rw, input logic [1:0] wb,
                                 input logic [7:0] op, input logic im, input logic zx,
                                 input logic ps);
        outs_t o;
        o.state = st; o.ir_we = ir; o.pc_we = pcw; o.pc_sel = pcs; o.addr_sel = as;
        o.mem_req = rq; o.mem_we = mw; o.reg_we = rw; o.wb_sel = wb; o.alu_op = op;
        o.alu_imm_sel = im; o.imm_zext = zx; o.psr_we = ps;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     name, act, exp, act.state, exp.state);
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic [4:0] fl, input logic rdy,
                        input outs_t exp, input string name);
        @(negedge clk);
        instr = ins; flags = fl; mem_ready = rdy;
        #1;
        check(name, exp);
    endtask

    task automatic add_vec(input string n, input logic [15:0] i, input logic [4:0] f,
                           input outs_t e);
        vec_t v;
        v.name = n; v.ins = i; v.fl = f; v.exp = e;
        vecs.push_back(v);
    endtask

    // Reference model: instruction mnemonics and condition meanings straight from the ISA
    function automatic string mnemonic(input logic [3:0] opc, input logic [3:0] ext);
        string r = "";
        if (opc == 4'h0) begin
            case (ext)
                4'h1: r = "AND";  4'h2: r = "OR";   4'h3: r = "XOR";  4'h5: r = "ADD";
                4'h6: r = "ADDU"; 4'h9: r = "SUB";  4'hB: r = "CMP";  4'hD: r = "MOV";
                default: r = "";
            endcase
        end else if (opc == 4'h8) begin
            case (ext)
                4'h0, 4'h1: r = "LSHI"; 4'h4: r = "LSH";
                4'h2, 4'h3: r = "ASHUI"; 4'h6: r = "ASHU";
                default: r = "";
            endcase
        end else begin
            case (opc)
                4'h1: r = "ANDI"; 4'h2: r = "ORI";  4'h3: r = "XORI"; 4'h5: r = "ADDI";
                4'h6: r = "ADDUI"; 4'h9: r = "SUBI"; 4'hB: r = "CMPI"; 4'hD: r = "MOVI";
                4'hF: r = "LUI";
                default: r = "";
            endcase
        end
        return r;
    endfunction

    function automatic logic holds(input logic [3:0] c, input logic [4:0] f);
        logic n, z, l, fl, cy;
        {n, z, l, fl, cy} = f;
        case (c)
            4'd0: return z;        4'd1: return !z;
            4'd2: return cy;       4'd3: return !cy;
            4'd4: return l;        4'd5: return !l;
            4'd6: return n;        4'd7: return !n;
            4'd8: return fl;       4'd9: return !fl;
            4'd10: return !(l || z);
            4'd11: return l || z;
            4'd12: return !(n || z);
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic r, input outs_t o, input string n);
        step_t s;
        s.rdy = r; s.exp = o; s.name = n;
        trace.push_back(s);
    endtask

    task automatic build_trace(input logic [15:0] ins, input logic [4:0] fl,
                               input int fw, input int mw);
        outs_t o;
        logic [3:0] opc, ext;
        string m;
        opc = ins[15:12];
        ext = ins[7:4];
        trace.delete();
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1'b1;
            push(1'b0, o, "fetch_wait");
        end
        o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1;
        push(1'b1, o, "fetch");
        o = '0; o.state = 3'd1;
        push(1'($urandom_range(0, 1)), o, "decode");
        o = '0;
        if (opc == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            o.state = 3'd3; o.addr_sel = 1'b1; o.mem_req = 1'b1; o.mem_we = (ext == 4'h4);
            for (int i = 0; i < mw; i++) push(1'b0, o, "mem_wait");
            o.pc_we = 1'b1;
            if (ext == 4'h0) begin o.reg_we = 1'b1; o.wb_sel = 2'b01; end
            push(1'b1, o, "mem_done");
        end else if (opc == 4'h4 && ext == 4'h8) begin
            o.state = 3'd6; o.reg_we = 1'b1; o.wb_sel = 2'b10; o.pc_we = 1'b1; o.pc_sel = 2'b10;
            push(1'($urandom_range(0, 1)), o, "jal");
        end else if (opc == 4'h4 && ext == 4'hC) begin
            o.state = 3'd5; o.pc_we = 1'b1; o.pc_sel = holds(ins[11:8], fl) ? 2'b10 : 2'b00;
            push(1'($urandom_range(0, 1)), o, "jump");
        end else if (opc == 4'hC) begin
            o.state = 3'd4; o.pc_we = 1'b1; o.pc_sel = holds(ins[11:8], fl) ? 2'b01 : 2'b00;
            push(1'($urandom_range(0, 1)), o, "branch");
        end else begin
            m = mnemonic(opc, ext);
            o.state = 3'd2; o.pc_we = 1'b1; o.alu_op = {opc, ext};
            if (m.len() > 0) begin
                o.psr_we      = 1'b1;
                o.reg_we      = !(m == "CMP" || m == "CMPI");
                o.alu_imm_sel = (m.substr(m.len() - 1, m.len() - 1) == "I") || (m == "LUI");
                o.imm_zext    = (m == "ANDI" || m == "ORI" || m == "XORI" ||
                                 m == "MOVI" || m == "LUI");
            end
            push(1'($urandom_range(0, 1)), o, "exec");
        end
    endtask

    outs_t fetch_exp, fetch_wait_exp, decode_exp, zero_exp, memw_exp;

    initial begin
        logic [15:0] ri;
        logic [4:0]  rf;
        int          req_cnt;
        int          fw, mw;

        fetch_exp      = mk(3'd0, 1, 0, 2'd0, 0, 1, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        fetch_wait_exp = mk(3'd0, 0, 0, 2'd0, 0, 1, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        decode_exp     = mk(3'd1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        zero_exp       = '0;
        memw_exp       = mk(3'd3, 0, 0, 2'd0, 1, 1, 0, 0, 2'd0, 8'h00, 0, 0, 0);

        //        name          instr     flags {N,Z,L,F,C}  expected action-cycle outputs
        add_vec("add",       16'h0152, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'h05, 0, 0, 1));
        add_vec("cmpi_m1",   16'hB3FF, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'hBF, 1, 0, 1));
        add_vec("cmp",       16'h01B2, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h0B, 0, 0, 1));
        add_vec("andi",      16'h11FF, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'h1F, 1, 1, 1));
        add_vec("lui",       16'hF1AB, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'hFA, 1, 1, 1));
        add_vec("lsh",       16'h8143, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'h84, 0, 0, 1));
        add_vec("lshi",      16'h8102, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'h80, 1, 0, 1));
        add_vec("nop",       16'h0000, 5'b11111, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("undef0070", 16'h0070, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h07, 0, 0, 0));
        add_vec("undef7123", 16'h7123, 5'b00000, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h72, 0, 0, 0));
        add_vec("load",      16'h4405, 5'b00000, mk(3'd3, 0, 1, 2'd0, 1, 1, 0, 1, 2'd1, 8'h00, 0, 0, 0));
        add_vec("stor",      16'h4145, 5'b00000, mk(3'd3, 0, 1, 2'd0, 1, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("beq_z1",    16'hC0FE, 5'b01000, mk(3'd4, 0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("beq_z0",    16'hC0FE, 5'b10111, mk(3'd4, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("blo_true",  16'hCA05, 5'b00000, mk(3'd4, 0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("blo_false", 16'hCA05, 5'b00100, mk(3'd4, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("bge_n",     16'hCD05, 5'b10000, mk(3'd4, 0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("juc",       16'h4EC6, 5'b00000, mk(3'd5, 0, 1, 2'd2, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("j_never",   16'h4FC6, 5'b11111, mk(3'd5, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0));
        add_vec("jal",       16'h4F86, 5'b00000, mk(3'd6, 0, 1, 2'd2, 0, 0, 0, 1, 2'd2, 8'h00, 0, 0, 0));

        rst_n = 1'b0; instr = 16'h0000; flags = 5'b0; mem_ready = 1'b0;
        step(16'h0152, 5'b11111, 1'b0, zero_exp, "reset_hold");
        step(16'h0152, 5'b11111, 1'b1, zero_exp, "reset_hold_ready");
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;
        #1;
        check("reset_release", fetch_wait_exp);

        foreach (vecs[i]) begin
            step(vecs[i].ins, vecs[i].fl, 1'b1, fetch_exp, {vecs[i].name, "_fetch"});
            step(vecs[i].ins, vecs[i].fl, 1'b0, decode_exp, {vecs[i].name, "_decode"});
            step(vecs[i].ins, vecs[i].fl, 1'b1, vecs[i].exp, vecs[i].name);
        end

        // LOAD with three stalled MEM cycles: request held four cycles, writeback on the last
        req_cnt = 0;
        step(16'h4405, 5'b0, 1'b1, fetch_exp, "ldw_fetch");
        step(16'h4405, 5'b0, 1'b1, decode_exp, "ldw_decode");
        for (int i = 0; i < 3; i++) begin
            step(16'h4405, 5'b0, 1'b0, memw_exp, "ldw_wait");
            if (mem_req && state == 3'd3) req_cnt++;
        end
        step(16'h4405, 5'b0, 1'b1, mk(3'd3, 0, 1, 2'd0, 1, 1, 0, 1, 2'd1, 8'h00, 0, 0, 0), "ldw_done");
        if (mem_req && state == 3'd3) req_cnt++;
        n_tests++;
        if (req_cnt != 4) begin
            n_fail++;
            $display("FAIL ldw_req_cycles: got %0d expected 4", req_cnt);
        end
        step(16'h0152, 5'b0, 1'b0, fetch_wait_exp, "ldw_back_to_fetch");
        step(16'h0152, 5'b0, 1'b1, fetch_exp, "ldw_next_fetch");
        step(16'h0152, 5'b0, 1'b0, decode_exp, "ldw_next_decode");
        step(16'h0152, 5'b0, 1'b0, mk(3'd2, 0, 1, 2'd0, 0, 0, 0, 1, 2'd0, 8'h05, 0, 0, 1), "ldw_next_exec");

        // flags only matter in the branch cycle itself
        step(16'hC0FE, 5'b01000, 1'b1, fetch_exp, "ft1_fetch");
        step(16'hC0FE, 5'b01000, 1'b0, decode_exp, "ft1_decode");
        step(16'hC0FE, 5'b00000, 1'b0, mk(3'd4, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0), "ft1_branch");
        step(16'hC0FE, 5'b00000, 1'b1, fetch_exp, "ft2_fetch");
        step(16'hC0FE, 5'b00000, 1'b0, decode_exp, "ft2_decode");
        step(16'hC0FE, 5'b01000, 1'b0, mk(3'd4, 0, 1, 2'd1, 0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0), "ft2_branch");

        // asynchronous reset in the middle of a stalled store
        step(16'h4145, 5'b0, 1'b1, fetch_exp, "rstmid_fetch");
        step(16'h4145, 5'b0, 1'b0, decode_exp, "rstmid_decode");
        step(16'h4145, 5'b0, 1'b0, mk(3'd3, 0, 0, 2'd0, 1, 1, 1, 0, 2'd0, 8'h00, 0, 0, 0), "rstmid_wait");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_asserted", zero_exp);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_released", fetch_wait_exp);

        for (int k = 0; k < 300; k++) begin
            ri = 16'($urandom);
            case ($urandom_range(0, 3))
                0: begin ri[15:12] = 4'h4; ri[7:4] = {2'($urandom_range(0, 3)), 2'b00}; end
                1: ri[15:12] = 4'hC;
                default: ;
            endcase
            rf = 5'($urandom);
            fw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 3));
            build_trace(ri, rf, fw, mw);
            foreach (trace[i]) begin
                step(ri, rf, trace[i].rdy, trace[i].exp,
                     $sformatf("rand%0d_%s_i%04h", k, trace[i].name, ri));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
